// File: rtl/sudoku_pkg.sv
// Shared constants, FSM encoding and board-index helpers for the 4x4 sudoku checker.
package sudoku_pkg;

    localparam int BOX        = 2;
    localparam int SIDE       = BOX * BOX;
    localparam int VAL_W      = 2;
    localparam int ADDR_W     = 4;
    localparam int UNIT_W     = $clog2(SIDE);
    localparam int CELL_W     = VAL_W + 1;
    localparam int FILLED_BIT = VAL_W;
    localparam int LAST_ADDR  = SIDE * SIDE - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [UNIT_W-1:0] unit_t;
    typedef logic [VAL_W-1:0]  val_t;
    typedef logic [ADDR_W-1:0] addr_t;

    function automatic unit_t row_of(input addr_t a);
        return unit_t'(a / addr_t'(SIDE));
    endfunction

    function automatic unit_t col_of(input addr_t a);
        return unit_t'(a % addr_t'(SIDE));
    endfunction

    function automatic unit_t box_of(input addr_t a);
        unit_t r;
        unit_t c;
        r = row_of(a);
        c = col_of(a);
        return unit_t'((r / unit_t'(BOX)) * unit_t'(BOX) + c / unit_t'(BOX));
    endfunction

endpackage

// File: rtl/sudoku_unit_tracker.sv
// One-hot "value already seen" bitmap per unit (row, column or box) with a
// combinational duplicate flag for the currently presented unit/value.
module sudoku_unit_tracker
    import sudoku_pkg::*;
(
    input  logic  clka,
    input  logic  restart_n,
    input  logic  clr,
    input  logic  set_en,
    input  unit_t unit,
    input  val_t  value,
    output logic  dup
);

    logic [SIDE-1:0][SIDE-1:0] seen;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            seen <= '0;
        end else if (clr) begin
            seen <= '0;
        end else if (set_en) begin
            seen[unit][value] <= 1'b1;
        end
    end

    assign dup = seen[unit][value];

endmodule

// File: rtl/sudoku_check_responder.sv
// Scans the board through the RAM read port on dp_check and reports whether the
// board is completely filled with no repeated value in any row, column or box.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for dp_check
// ST_SCAN  | issuing reads for addresses 0..LAST_ADDR, one per cycle
// ST_DRAIN | capturing the data for the last address
// ST_DONE  | check_done pulse; solved/fill_count already registered
module sudoku_check_responder
    import sudoku_pkg::*;
(
    input  logic              clka,
    input  logic              restart_n,
    input  logic              game_rst,
    input  logic              dp_check,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              check_done,
    output logic              solved,
    output logic [ADDR_W:0]   fill_count
);

    state_t          state;
    state_t          state_nxt;
    logic            start;
    logic            rd_vld;
    logic [ADDR_W-1:0] cap_addr;
    logic            err_q;
    logic            err_nxt;
    logic [ADDR_W:0] cnt_q;
    logic [ADDR_W:0] cnt_nxt;
    logic            cell_filled;
    val_t            cell_value;
    logic            cell_err;
    logic            set_en;
    logic            clr;
    logic            dup_row;
    logic            dup_col;
    logic            dup_box;

    assign start = (state == ST_IDLE) && dp_check && !game_rst;
    assign clr   = start || game_rst;

    assign cell_filled = rd_data[FILLED_BIT];
    assign cell_value  = rd_data[VAL_W-1:0];
    // an unfilled cell fails the board; its value bits are meaningless
    assign cell_err    = !cell_filled || dup_row || dup_col || dup_box;
    assign set_en      = rd_vld && cell_filled && !game_rst;
    assign err_nxt     = err_q || (rd_vld && cell_err);
    assign cnt_nxt     = cnt_q + (ADDR_W+1)'(rd_vld && cell_filled);

    sudoku_unit_tracker u_rows (
        .clka      (clka),
        .restart_n (restart_n),
        .clr       (clr),
        .set_en    (set_en),
        .unit      (row_of(cap_addr)),
        .value     (cell_value),
        .dup       (dup_row)
    );

    sudoku_unit_tracker u_cols (
        .clka      (clka),
        .restart_n (restart_n),
        .clr       (clr),
        .set_en    (set_en),
        .unit      (col_of(cap_addr)),
        .value     (cell_value),
        .dup       (dup_col)
    );

    sudoku_unit_tracker u_boxes (
        .clka      (clka),
        .restart_n (restart_n),
        .clr       (clr),
        .set_en    (set_en),
        .unit      (box_of(cap_addr)),
        .value     (cell_value),
        .dup       (dup_box)
    );

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (game_rst) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nxt = ST_SCAN;
                ST_SCAN:  if (rd_addr == ADDR_W'(LAST_ADDR)) state_nxt = ST_DRAIN;
                ST_DRAIN: state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en      = 1'b0;
        busy       = 1'b0;
        check_done = 1'b0;
        case (state)
            ST_SCAN:  begin rd_en = 1'b1; busy = 1'b1; end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  begin busy = 1'b1; check_done = 1'b1; end
            default:  ;
        endcase
    end

    // rd_vld marks the cycle in which rd_data belongs to cap_addr
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            rd_addr    <= '0;
            cap_addr   <= '0;
            rd_vld     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            solved     <= 1'b0;
            fill_count <= '0;
        end else if (game_rst) begin
            rd_vld     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            solved     <= 1'b0;
            fill_count <= '0;
        end else begin
            rd_vld   <= (state == ST_SCAN);
            cap_addr <= rd_addr;
            if (start) begin
                rd_addr <= '0;
                err_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                if (state == ST_SCAN && rd_addr != ADDR_W'(LAST_ADDR)) begin
                    rd_addr <= rd_addr + 1'b1;
                end
                err_q <= err_nxt;
                cnt_q <= cnt_nxt;
            end
            // the last cell is captured during DRAIN, so commit the merged result
            if (state == ST_DRAIN) begin
                solved     <= !err_nxt;
                fill_count <= cnt_nxt;
            end
        end
    end

endmodule
